// File: rtl/demux9bit_1to2_pkg.sv
// Shared definitions for the 9-bit 1:2 demultiplexer: select codes,
// discard counter width and default word width / FIFO depth.
// No logic; imported by the top level.
package demux9bit_1to2_pkg;

  localparam int DEFAULT_WIDTH = 9;
  localparam int DEFAULT_DEPTH = 2;
  localparam int DROP_CNT_W    = 8;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A = 2'd0;
  localparam sel_t SEL_B = 2'd1;

  // Codes 2 and 3 both mean "discard": only the upper bit matters.
  function automatic logic is_discard(input sel_t sel);
    return sel[1];
  endfunction

endpackage

// File: rtl/demux9bit_1to2_sync_fifo.sv
// Purpose: single-clock FIFO, DEPTH entries of WIDTH bits, registered storage.
// Latency: a word pushed at edge N is visible on rdata after edge N (no bypass).
// Backpressure: push ignored while full (even with a same-cycle pop); pop ignored while empty.
// Ports: Clk, Rst (async active-low), push/wdata write side, pop/rdata read side,
//        full/empty status derived from the occupancy count.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Full blocks the write even when a pop frees a slot in the same cycle,
  // so in_ready upstream never depends on the consumer's ready.
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  // Head entry; when empty it shows whatever was last stored there (0 after reset).
  assign rdata = mem[rptr];

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + PW'(1);
      end
      if (rd_en) begin
        rptr <= rptr + PW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux9bit_1to2.sv
// Purpose: buffered 1:2 demux; routes each accepted word to FIFO A or B by in_sel, drops codes 2/3.
// Latency: one cycle from accepting edge to out*_valid.
// Backpressure: in_ready depends only on in_sel and the selected FIFO's full flag; discards always accepted.
// Ports: in_data/in_sel/in_valid/in_ready input channel; outA_*/outB_* output channels
//        (valid/ready); drop_count saturating discard counter; err sticky discard flag.
module demux9bit_1to2
  import demux9bit_1to2_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [1:0]            in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      outA_data,
  output logic                  outA_valid,
  input  logic                  outA_ready,
  output logic [WIDTH-1:0]      outB_data,
  output logic                  outB_valid,
  input  logic                  outB_ready,
  output logic [DROP_CNT_W-1:0] drop_count,
  output logic                  err
);

  logic full_a, empty_a;
  logic full_b, empty_b;
  logic accept;
  logic push_a, push_b;
  logic pop_a, pop_b;
  logic discard;

  always_comb begin
    in_ready = 1'b1;
    case (in_sel)
      SEL_A:   in_ready = !full_a;
      SEL_B:   in_ready = !full_b;
      default: in_ready = 1'b1;
    endcase
  end

  assign accept  = in_valid && in_ready;
  assign push_a  = accept && (in_sel == SEL_A);
  assign push_b  = accept && (in_sel == SEL_B);
  assign discard = accept && is_discard(in_sel);

  assign outA_valid = !empty_a;
  assign outB_valid = !empty_b;
  assign pop_a      = outA_valid && outA_ready;
  assign pop_b      = outB_valid && outB_ready;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_a (
    .Clk   (Clk),
    .Rst   (Rst),
    .push  (push_a),
    .pop   (pop_a),
    .wdata (in_data),
    .rdata (outA_data),
    .full  (full_a),
    .empty (empty_a)
  );

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_b (
    .Clk   (Clk),
    .Rst   (Rst),
    .push  (push_b),
    .pop   (pop_b),
    .wdata (in_data),
    .rdata (outB_data),
    .full  (full_b),
    .empty (empty_b)
  );

  // Discard bookkeeping: counter saturates at all-ones, err is sticky until reset.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      drop_count <= '0;
      err        <= 1'b0;
    end else if (discard) begin
      if (drop_count != '1) begin
        drop_count <= drop_count + DROP_CNT_W'(1);
      end
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_demux9bit_1to2.sv
// Scoreboard bench for demux9bit_1to2: stimulus pushes expected words per output,
// a negedge monitor pops and compares on every output handshake.
module tb_demux9bit_1to2;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [8:0] in_data;
  logic [1:0] in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] outA_data;
  logic       outA_valid;
  logic       outA_ready;
  logic [8:0] outB_data;
  logic       outB_valid;
  logic       outB_ready;
  logic [7:0] drop_count;
  logic       err;

  int errors = 0;
  int checks = 0;
  logic [8:0] qa[$];
  logic [8:0] qb[$];

  always #5 Clk = ~Clk;

  demux9bit_1to2 dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .outA_data  (outA_data),
    .outA_valid (outA_valid),
    .outA_ready (outA_ready),
    .outB_data  (outB_data),
    .outB_valid (outB_valid),
    .outB_ready (outB_ready),
    .drop_count (drop_count),
    .err        (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake must match the oldest expected word.
  always @(negedge Clk) begin
    if (Rst === 1'b1) begin
      if (outA_valid && outA_ready) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL outA_unexpected: got word %0h, expected none", outA_data);
        end else begin
          chk("outA_data", outA_data, qa.pop_front());
        end
      end
      if (outB_valid && outB_ready) begin
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL outB_unexpected: got word %0h, expected none", outB_data);
        end else begin
          chk("outB_data", outB_data, qb.pop_front());
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [8:0] d, input logic [1:0] s);
    int w = 0;
    in_data  = d;
    in_sel   = s;
    in_valid = 1'b1;
    @(negedge Clk);
    while (!in_ready && w < 20) begin
      w++;
      @(negedge Clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for word %0h sel %0d, expected 1", d, s);
    end else if (s == 2'd0) begin
      qa.push_back(d);
    end else if (s == 2'd1) begin
      qb.push_back(d);
    end
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst        = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_sel     = 2'd0;
    outA_ready = 1'b0;
    outB_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_outA_valid", outA_valid, 0);
    chk("rst_outB_valid", outB_valid, 0);
    chk("rst_outA_data", outA_data, 0);
    chk("rst_outB_data", outB_data, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_err", err, 0);
    @(negedge Clk);
    Rst = 1'b1;
    idle(1);
    in_sel = 2'd0; #1 chk("idle_ready_sel0", in_ready, 1);
    in_sel = 2'd1; #1 chk("idle_ready_sel1", in_ready, 1);
    in_sel = 2'd2; #1 chk("idle_ready_sel2", in_ready, 1);
    idle(1);

    // Alternating routing, both consumers ready, back-to-back words
    outA_ready = 1'b1;
    outB_ready = 1'b1;
    send(9'h001, 2'd0);
    chk("alt_a1_valid", outA_valid, 1);
    chk("alt_a1_data", outA_data, 9'h001);
    send(9'h1FF, 2'd1);
    chk("alt_b_valid", outB_valid, 1);
    chk("alt_b_data", outB_data, 9'h1FF);
    chk("alt_a_drained", outA_valid, 0);
    send(9'h0AA, 2'd0);
    chk("alt_a2_valid", outA_valid, 1);
    chk("alt_a2_data", outA_data, 9'h0AA);
    idle(3);
    chk("alt_qa_empty", qa.size(), 0);
    chk("alt_qb_empty", qb.size(), 0);

    // Back-pressure on A; B keeps flowing
    outA_ready = 1'b0;
    send(9'h101, 2'd0);
    send(9'h102, 2'd0);
    in_sel = 2'd0; #1 chk("bp_ready_sel0_full", in_ready, 0);
    in_sel = 2'd1; #1 chk("bp_ready_sel1", in_ready, 1);
    send(9'h155, 2'd1);
    chk("bp_b_valid", outB_valid, 1);
    chk("bp_a_held", outA_data, 9'h101);
    idle(2);
    chk("bp_qb_empty", qb.size(), 0);
    outA_ready = 1'b1;
    idle(3);
    chk("bp_qa_empty", qa.size(), 0);
    chk("bp_a_empty", outA_valid, 0);

    // Full FIFO with simultaneous pop: push refused that cycle, taken next cycle
    outA_ready = 1'b0;
    send(9'h011, 2'd0);
    send(9'h022, 2'd0);
    outA_ready = 1'b1;
    in_data  = 9'h033;
    in_sel   = 2'd0;
    in_valid = 1'b1;
    @(negedge Clk);
    chk("fullpop_ready0", in_ready, 0);
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("fullpop_ready1", in_ready, 1);
    if (in_ready) qa.push_back(9'h033);
    @(posedge Clk); #1;
    in_valid = 1'b0;
    idle(3);
    chk("fullpop_qa_empty", qa.size(), 0);

    // Discards
    send(9'h1AA, 2'd2);
    send(9'h0F0, 2'd3);
    send(9'h155, 2'd2);
    chk("drop3_count", drop_count, 3);
    chk("drop3_err", err, 1);
    chk("drop3_a_idle", outA_valid, 0);
    chk("drop3_b_idle", outB_valid, 0);
    in_sel   = 2'd3;
    in_valid = 1'b1;
    repeat (300) @(posedge Clk);
    #1;
    in_valid = 1'b0;
    chk("drop_sat_count", drop_count, 255);
    chk("drop_sat_err", err, 1);

    // Reset mid-operation with both FIFOs occupied
    outA_ready = 1'b0;
    outB_ready = 1'b0;
    send(9'h0A5, 2'd0);
    send(9'h15A, 2'd1);
    chk("mid_a_valid", outA_valid, 1);
    chk("mid_b_valid", outB_valid, 1);
    qa.delete();
    qb.delete();
    @(negedge Clk);
    #2;
    Rst = 1'b0;
    #1;
    chk("mid_rst_a_valid", outA_valid, 0);
    chk("mid_rst_b_valid", outB_valid, 0);
    chk("mid_rst_a_data", outA_data, 0);
    chk("mid_rst_drop", drop_count, 0);
    chk("mid_rst_err", err, 0);
    @(negedge Clk);
    Rst = 1'b1;
    idle(1);
    in_sel = 2'd0; #1 chk("post_ready_sel0", in_ready, 1);
    in_sel = 2'd1; #1 chk("post_ready_sel1", in_ready, 1);

    // Traffic resumes normally after reset
    outA_ready = 1'b1;
    outB_ready = 1'b1;
    idle(1);
    send(9'h1C3, 2'd0);
    send(9'h03C, 2'd1);
    idle(3);
    chk("post_qa_empty", qa.size(), 0);
    chk("post_qb_empty", qb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux9bit_1to2.md
# demux9bit_1to2

Buffered 1-to-2 demultiplexer for 9-bit words: the routing counterpart of the 2:1 selection muxes in the datapath. It accepts one word per cycle on a valid/ready input channel and steers it, per a 2-bit select, into one of two independently back-pressured output channels. Each output has a small FIFO, so a stalled consumer on one side does not block traffic bound for the other. Invalid select codes are discarded and counted.

## Interface
- WIDTH, 9, data word width
- DEPTH, 2, entries per output FIFO; power of two, at least 2
- Clk  in  1  clock; all state updates on the rising edge
- Rst  in  1  reset; asynchronous, active-low
- in_data  in  WIDTH  input word
- in_sel  in  2  route select: 0 -> A, 1 -> B, 2 or 3 -> discard
- in_valid  in  1  in_data and in_sel are valid
- in_ready  out  1  block accepts the word this cycle
- outA_data  out  WIDTH  head word of FIFO A
- outA_valid  out  1  FIFO A is not empty
- outA_ready  in  1  consumer A takes the head word
- outB_data, outB_valid, outB_ready: same as A, for FIFO B
- drop_count  out  8  number of discarded words; saturates at 255
- err  out  1  sticky flag, set on the first discard

## Operation
- Accept: a word is accepted when in_valid && in_ready at the clock edge.
- in_ready is combinational on in_sel:
  - sel 0: !fullA
  - sel 1: !fullB
  - sel 2 or 3: 1 (the word is always accepted and discarded)
- Push: an accepted word with sel 0 is written to the tail of FIFO A; sel 1 writes FIFO B.
- Discard: an accepted word with sel 2 or 3 is dropped. drop_count increments (holding at 255) and err sets to 1. err clears only on reset.
- Pop: a FIFO pops its head when out*_valid && out*_ready.
- Ordering: each FIFO is strict first-in, first-out. There is no ordering relation between A and B.
- Full FIFO: no push occurs when the FIFO is full, even if it pops in the same cycle; in_ready is 0 for that select.
- Push and pop on the same FIFO in the same cycle: both happen and occupancy is unchanged.
- Empty FIFO with simultaneous push: no bypass. The word appears on the output the next cycle.
- Pointers: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. The occupancy count is log2(DEPTH)+1 bits.
  - full = (count == DEPTH)
  - empty = (count == 0)
- out*_data: the head entry when valid. When empty it holds the last stored value; the value is don't-care but not X after reset.
- Input stability: in_valid must not depend on in_ready. A producer holds in_data and in_sel stable while stalled.

## Timing
- Reset (Rst low, asynchronous):
  - counts and pointers go to 0; both FIFOs empty
  - outA_valid = outB_valid = 0
  - FIFO storage and out*_data = 0
  - drop_count = 0, err = 0
- Reset assertion mid-transfer loses all buffered words. On release, in_ready reflects empty FIFOs (1 for every select).
- Latency: accept at edge N gives out*_valid high after edge N (one cycle).
- Throughput: one word per cycle into each FIFO while it is not full.
- Discard: drop_count and err update at the accepting edge.
- Combinational paths:
  - in_sel -> in_ready
  - no path from out*_ready to in_ready

## Structure
- Shared package:
  - SEL_A = 2'd0, SEL_B = 2'd1
  - DROP_CNT_W = 8
  - default WIDTH = 9
- One sub-module, sync_fifo: parameters WIDTH and DEPTH; ports Clk, Rst, push, pop, wdata, rdata, full, empty. Instantiated twice.
- Top level contains the select decode, in_ready logic and discard counter.

## Test plan
- Reset then idle: with Rst low, all outputs are 0; after release, in_ready = 1 for sel 0, 1 and 2.
- Alternating routing: send 9'h001 (sel 0), 9'h1FF (sel 1), 9'h0AA (sel 0), with both ready held 1 -> A emits 001 then 0AA, B emits 1FF, each one cycle after acceptance.
- Back-pressure: outA_ready = 0, push three words to A -> first two accepted, in_ready drops for sel 0; a sel 1 word is still accepted and emitted on B; raising outA_ready drains A in order.
- Full with simultaneous pop: FIFO A full, outA_ready = 1, in_valid with sel 0 -> pop occurs, push refused that cycle, accepted on the next cycle.
- Discard: send 3 words with sel 2/3 -> drop_count = 3, err = 1, no output activity; send 300 discards -> drop_count holds at 255.
- Reset mid-operation: assert Rst with both FIFOs holding data -> outA_valid and outB_valid drop immediately (asynchronously), drop_count and err return to 0.
